div_seq: RTL and testbench
==========================

# div_seq

Sequential iterative divider for the non-linear-ops datapath; the counterpart of the combinational `mult` block. It computes quotient and remainder of two WIDTH-bit operands with one restoring-division step per clock. Used by softmax/normalisation stages that need a reciprocal or ratio. Valid/ready handshake on both sides; one operation in flight.

## Interface

Parameters:
- WIDTH, 64, operand, quotient and remainder width (≥ 2)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- div_valid_i  input  1  operands valid
- div_ready_o  output  1  block can accept operands (high only in IDLE, low while rst)
- div_i1  input  WIDTH  dividend
- div_i2  input  WIDTH  divisor
- div_valid_o  output  1  result valid
- div_ready_i  input  1  downstream accepts result
- div_q_o  output  WIDTH  quotient
- div_r_o  output  WIDTH  remainder
- div_by_zero_o  output  1  result came from a zero divisor; valid with div_valid_o

## Operation

- States: IDLE, BUSY, DONE. Reset → IDLE; all outputs 0 except div_ready_o, which is 0 during rst and 1 in IDLE.
- IDLE: div_ready_o=1. On div_valid_i & div_ready_o, capture operands and clear the iteration counter.
  - If div_i2==0: go to DONE; q=all ones, r=div_i1, div_by_zero_o=1.
  - Otherwise go to BUSY.
- BUSY: restoring step per cycle. Shift {rem, quo} left by 1, bringing in the next dividend MSB. Trial-subtract divisor from rem using a WIDTH+1-bit difference. If non-negative, keep the difference and set the quotient LSB to 1. After WIDTH steps (counter reaches WIDTH-1), go to DONE.
- DONE: div_valid_o=1; div_q_o, div_r_o and div_by_zero_o are held stable until div_valid_o & div_ready_i. Then go to IDLE, clear div_valid_o and div_by_zero_o; q/r outputs keep their last values.
- div_valid_i is ignored outside IDLE. div_i1/div_i2 need be stable only on the accept edge.
- No back-to-back overlap: ready is re-asserted the cycle after result handoff.
- rst asserted in any state aborts the operation; the next cycle is IDLE with outputs cleared, and no result is emitted.
- Unsigned arithmetic by default; results are exact with q*div_i2 + r == div_i1 and r < div_i2.

## Timing

- Accept on edge k (IDLE, valid&ready).
- Nonzero divisor: BUSY on edges k+1..k+WIDTH; div_valid_o high after edge k+WIDTH (WIDTH cycles after accept).
- Zero divisor: div_valid_o high after edge k+1.
- Handoff on edge m (div_valid_o & div_ready_i): IDLE and div_ready_o=1 after edge m. The earliest next accept is edge m+1.
- Throughput for nonzero divisors: one result per WIDTH+2 cycles with div_ready_i tied high.
- Outputs are registered, except div_ready_o, which is decoded from state and rst.

## Configuration

- DIV_SIGNED_EN defined: operands and results are two's complement.
  - Magnitudes are taken on accept.
  - The quotient truncates toward zero and is negated if operand signs differ.
  - The remainder takes the dividend's sign.
  - Sign fix-up is applied when entering DONE, with no extra cycle.
  - MIN / -1 gives q=MIN (wrap), r=0.
  - Zero divisor gives q=all ones (-1), r=div_i1, div_by_zero_o=1.
- DIV_SIGNED_EN undefined: unsigned only, with no sign logic synthesised.

## Test plan

- WIDTH=8, unsigned, 200/7, div_ready_i=1 → div_valid_o 8 cycles after accept, q=28, r=4, div_by_zero_o=0; div_ready_o high the following cycle.
- WIDTH=8, 55/0 → div_valid_o 1 cycle after accept, q=255, r=55, div_by_zero_o=1.
- WIDTH=8, 255/1, div_ready_i held low for 5 cycles after valid → q=255, r=0 held stable throughout; handoff on the first cycle with ready high; div_valid_i pulses during BUSY/DONE are ignored.
- WIDTH=8, accept 100/3, assert rst for 1 cycle at BUSY step 4 → no div_valid_o; all outputs 0; div_ready_o=1 the cycle after rst deasserts; a following 9/2 yields q=4, r=1.
- WIDTH=8, DIV_SIGNED_EN: -7/2 → q=-3 (0xFD), r=-1 (0xFF); 7/-2 → q=-3, r=1; -128/-1 → q=-128 (0x80), r=0.
- Randomised 1000 operand pairs (WIDTH=16, random ready stalls) checked against a reference model for q, r and latency.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, one quotient bit per clock.
// Valid/ready on operands and on results, one operation in flight.
// Optional build macro DIV_SIGNED_EN: two's complement operands/results
// (magnitudes divided, signs fixed up on the way into DONE). Without it the
// block is unsigned only and carries no sign logic.
module div_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_valid_i,
    output logic             div_ready_o,
    input  logic [WIDTH-1:0] div_i1,
    input  logic [WIDTH-1:0] div_i2,
    output logic             div_valid_o,
    input  logic             div_ready_i,
    output logic [WIDTH-1:0] div_q_o,
    output logic [WIDTH-1:0] div_r_o,
    output logic             div_by_zero_o
);
    localparam int                CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] rem_q;      // partial remainder (raw dividend when divisor is zero)
    logic [WIDTH-1:0] quo_q;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_q;      // divisor magnitude
    logic [CNT_W-1:0] cnt_q;
    logic             zero_q;     // current operation has a zero divisor
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic             valid_q;
    logic             dbz_q;

    // Two's complement negate when neg is set, pass-through otherwise.
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // Next-step values of the restoring iteration.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             fits;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

`ifdef DIV_SIGNED_EN
    logic neg_q_q;
    logic neg_r_q;
`endif

    // Shift {rem, quo} left by one and trial-subtract the divisor.
    always_comb begin
        rem_sh         = {rem_q, quo_q[WIDTH-1]};
        {borrow, diff} = {1'b0, rem_sh} - {2'b00, dvs_q};
        fits           = ~borrow;
        rem_d          = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_d          = {quo_q[WIDTH-2:0], fits};
    end

    // Operand magnitudes on accept and sign fix-up of the final step.
    always_comb begin
`ifdef DIV_SIGNED_EN
        mag1  = apply_sign(div_i1, div_i1[WIDTH-1]);
        mag2  = apply_sign(div_i2, div_i2[WIDTH-1]);
        q_fin = apply_sign(quo_d, neg_q_q);
        r_fin = apply_sign(rem_d, neg_r_q);
`else
        mag1  = div_i1;
        mag2  = div_i2;
        q_fin = quo_d;
        r_fin = rem_d;
`endif
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_valid_i) begin
                        state_q <= BUSY;
                        cnt_q   <= '0;
                        zero_q  <= (div_i2 == '0);
                        dvs_q   <= mag2;
                        quo_q   <= mag1;
                        rem_q   <= (div_i2 == '0) ? div_i1 : '0;
`ifdef DIV_SIGNED_EN
                        neg_q_q <= div_i1[WIDTH-1] ^ div_i2[WIDTH-1];
                        neg_r_q <= div_i1[WIDTH-1];
`endif
                    end
                end
                BUSY: begin
                    // A zero divisor spends exactly one cycle here so its
                    // result appears one cycle after accept.
                    if (zero_q) begin
                        state_q <= DONE;
                        q_q     <= '1;
                        r_q     <= rem_q;
                        dbz_q   <= 1'b1;
                        valid_q <= 1'b1;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            state_q <= DONE;
                            q_q     <= q_fin;
                            r_q     <= r_fin;
                            valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (div_ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        dbz_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign div_ready_o   = (state_q == IDLE) && !rst;
    assign div_valid_o   = valid_q;
    assign div_q_o       = q_q;
    assign div_r_o       = r_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq (WIDTH=16). The driver pushes the
// reference result of every accepted operation; a monitor pops and compares
// when the DUT presents a result. Define DIV_SIGNED_EN for both DUT and bench
// to exercise the signed build.
module tb_div_seq;
    localparam int W = 16;
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst;
    logic         div_valid_i;
    logic         div_ready_o;
    logic [W-1:0] div_i1;
    logic [W-1:0] div_i2;
    logic         div_valid_o;
    logic         div_ready_i;
    logic [W-1:0] div_q_o;
    logic [W-1:0] div_r_o;
    logic         div_by_zero_o;

    div_seq #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .div_valid_i   (div_valid_i),
        .div_ready_o   (div_ready_o),
        .div_i1        (div_i1),
        .div_i2        (div_i2),
        .div_valid_o   (div_valid_o),
        .div_ready_i   (div_ready_i),
        .div_q_o       (div_q_o),
        .div_r_o       (div_r_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           acc;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   stall_mode = 0;   // 0: ready high, 1: random stalls, 2: directed
    bit   holding = 1'b0;
    bit   prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Reference: plain arithmetic on the operands as integers.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        z = (b == '0);
        if (z) begin
            q = '1;
            r = a;
        end else begin
`ifdef DIV_SIGNED_EN
            longint sa, sb;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = W'(sa / sb);
            r = W'(sa % sb);
`else
            q = a / b;
            r = a % b;
`endif
        end
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        div_i1 = a;
        div_i2 = b;
        div_valid_i = 1'b1;
        while (!div_ready_o && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!div_ready_o) begin
            timeout_fail("accept_wait");
        end else begin
            model(a, b, e.q, e.r, e.z);
            e.acc = cyc + 1;
            e.lat = (b == '0) ? 1 : W;
            exp_q.push_back(e);
        end
        @(negedge clk);
        div_valid_i = 1'b0;
        div_i1 = W'($urandom);
        div_i2 = W'($urandom);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!(exp_q.size() == 0 && !holding && div_ready_o) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) timeout_fail("wait_idle");
    endtask

    // Ready driver for the non-directed phases.
    initial begin
        forever begin
            @(negedge clk);
            if (stall_mode == 0) div_ready_i = 1'b1;
            else if (stall_mode == 1) div_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compare each presented result with the queued expectation,
    // then check it stays stable until handed off.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                holding    = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (holding && prev_valid && div_ready_i) holding = 1'b0;
                if (div_valid_o) begin
                    if (!holding) begin
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_result: got q=%0h r=%0h, expected none", div_q_o, div_r_o);
                        end else begin
                            cur = exp_q.pop_front();
                            chk("quotient", 64'(div_q_o), 64'(cur.q));
                            chk("remainder", 64'(div_r_o), 64'(cur.r));
                            chk("div_by_zero", 64'(div_by_zero_o), 64'(cur.z));
                            chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
                            holding = 1'b1;
                        end
                    end else begin
                        chk("q_hold", 64'(div_q_o), 64'(cur.q));
                        chk("r_hold", 64'(div_r_o), 64'(cur.r));
                        chk("dbz_hold", 64'(div_by_zero_o), 64'(cur.z));
                    end
                end else if (holding) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL valid_dropped: got valid 0 without handoff, expected 1");
                    holding = 1'b0;
                end
                prev_valid = div_valid_o;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        logic [W-1:0] a, b;
        rst = 1'b1;
        div_valid_i = 1'b0;
        div_i1 = '0;
        div_i2 = '0;
        div_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("ready_in_reset", 64'(div_ready_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 64'(div_ready_o), 64'd1);
        chk("reset_valid", 64'(div_valid_o), 64'd0);
        chk("reset_q", 64'(div_q_o), 64'd0);
        chk("reset_r", 64'(div_r_o), 64'd0);
        chk("reset_dbz", 64'(div_by_zero_o), 64'd0);

        // 200/7 with ready tied high; ready returns right after handoff.
        issue(W'(200), W'(7));
        guard = 0;
        while (!div_valid_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!div_valid_o) timeout_fail("valid_200_7");
        @(negedge clk);
        chk("ready_after_handoff", 64'(div_ready_o), 64'd1);
        chk("valid_after_handoff", 64'(div_valid_o), 64'd0);
        wait_idle();

        // Zero divisor.
        issue(W'(55), W'(0));
        wait_idle();

        // All-ones / 1 with a stalled consumer and stray valid pulses.
        stall_mode = 2;
        div_ready_i = 1'b0;
        issue('1, W'(1));
        guard = 0;
        while (!div_valid_o && guard < 100) begin
            @(negedge clk);
            div_valid_i = guard[0];
            div_i1 = W'($urandom);
            div_i2 = '0;
            guard++;
        end
        if (!div_valid_o) timeout_fail("valid_ones_1");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            div_valid_i = (i % 2 == 0);
        end
        div_valid_i = 1'b0;
        div_ready_i = 1'b1;
        stall_mode = 0;
        wait_idle();
        chk("q_kept_after_handoff", 64'(div_q_o), 64'(16'hFFFF));

        // Reset in the middle of BUSY aborts the operation.
        issue(W'(100), W'(3));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("ready_during_abort", 64'(div_ready_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 64'(div_ready_o), 64'd1);
        chk("abort_valid", 64'(div_valid_o), 64'd0);
        chk("abort_q", 64'(div_q_o), 64'd0);
        chk("abort_r", 64'(div_r_o), 64'd0);
        chk("abort_dbz", 64'(div_by_zero_o), 64'd0);
        issue(W'(9), W'(2));
        wait_idle();

        // Sign-sensitive patterns (unsigned build checks them as unsigned).
        issue(W'(-7), W'(2));
        issue(W'(7), W'(-2));
        issue(MINV, '1);
        issue(MINV, W'(1));
        wait_idle();

        // Randomised operands with random result stalls.
        stall_mode = 1;
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 9))
                0: b = '0;
                1: b = W'($urandom_range(1, 7));
                2: b = '1;
                3: b = MINV;
                default: b = W'($urandom);
            endcase
            a = ($urandom_range(0, 9) == 0) ? MINV : W'($urandom);
            issue(a, b);
        end
        stall_mode = 0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
